// File: rtl/trng_sched_if.sv
// ============================================================================
// Module      : trng_sched_if
// Description : Requester, delivery and TRNG-side signals of trng_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trng_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [7:0]      rnd_data;
    logic            rnd_valid;
    logic            trng_enable;
    logic            trng_consume;
    logic [7:0]      trng_data;
    logic            trng_ready;
    logic            health_fail;
    logic            clear_fail;
    logic            busy;

    modport slave (
        input  req, trng_data, trng_ready, clear_fail,
        output grant, rnd_data, rnd_valid, trng_enable, trng_consume,
               health_fail, busy
    );

    modport master (
        output req, trng_data, trng_ready, clear_fail,
        input  grant, rnd_data, rnd_valid, trng_enable, trng_consume,
               health_fail, busy
    );
endinterface

`default_nettype wire

// File: rtl/trng_sched.sv
// ============================================================================
// Module      : trng_sched
// Description : TRNG enable gating, warm-up discard, repetition health test
//               and round-robin byte distribution to NREQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trng_sched #(
    parameter int NREQ         = 4,
    parameter int WARMUP_BYTES = 4,
    parameter int IDLE_CYCLES  = 64,
    parameter int REP_LIMIT    = 3
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    trng_sched_if.slave    bus
);
    localparam int              c_PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              c_SW        = c_PW + 1;
    localparam logic [c_SW-1:0] c_NREQ_S    = c_SW'(NREQ);
    localparam logic [7:0]      c_WARM_LAST = 8'(WARMUP_BYTES - 1);
    localparam logic [15:0]     c_IDLE_LAST = 16'(IDLE_CYCLES - 1);
    localparam logic [3:0]      c_REP_LIM   = 4'(REP_LIMIT);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SERVE  = 2'd2,
        ST_FAIL   = 2'd3
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [7:0]      r_rnd_data;
    logic            r_rnd_valid;
    logic            r_enable;
    logic            r_busy;
    logic            r_health_fail;
    logic [c_PW-1:0] r_rr_ptr;
    logic [7:0]      r_warm_cnt;
    logic [15:0]     r_idle_cnt;
    logic [3:0]      r_rep_cnt;
    logic [7:0]      r_last_byte;

    logic            w_any_req;
    logic            w_consume;
    logic [NREQ-1:0] w_req_rot;
    logic [c_PW-1:0] w_k;
    logic [c_SW-1:0] w_sum;
    logic [c_SW-1:0] w_sum_adj;
    logic [c_PW-1:0] w_win;
    logic [c_SW-1:0] w_win_p1;
    logic [c_PW-1:0] w_next_ptr;
    logic [NREQ-1:0] w_onehot;
    logic [3:0]      w_rep_next;
    logic            w_trip;

    assign w_any_req = |bus.req;
    assign w_consume = bus.trng_ready &&
                       ((r_state == ST_WARMUP) || ((r_state == ST_SERVE) && w_any_req));

    // Rotate requests so bit 0 is the requester at rr_ptr, then pick the lowest set bit.
    assign w_req_rot = NREQ'({bus.req, bus.req} >> r_rr_ptr);

    always_comb begin
        w_k = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_k = c_PW'(i);
            end
        end
    end

    assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_k};
    assign w_sum_adj  = (w_sum >= c_NREQ_S) ? (w_sum - c_NREQ_S) : w_sum;
    assign w_win      = c_PW'(w_sum_adj);
    assign w_win_p1   = {1'b0, w_win} + c_SW'(1);
    assign w_next_ptr = (w_win_p1 == c_NREQ_S) ? '0 : c_PW'(w_win_p1);
    assign w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;

    // rep_cnt==0 marks the first byte since leaving OFF/FAIL.
    assign w_rep_next = ((r_rep_cnt == 4'd0) || (bus.trng_data != r_last_byte)) ? 4'd1 :
                        (r_rep_cnt == 4'hF) ? 4'hF : (r_rep_cnt + 4'd1);
    assign w_trip     = (w_rep_next >= c_REP_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_OFF;
            r_grant       <= '0;
            r_rnd_data    <= 8'h00;
            r_rnd_valid   <= 1'b0;
            r_enable      <= 1'b0;
            r_busy        <= 1'b0;
            r_health_fail <= 1'b0;
            r_rr_ptr      <= '0;
            r_warm_cnt    <= 8'd0;
            r_idle_cnt    <= 16'd0;
            r_rep_cnt     <= 4'd0;
            r_last_byte   <= 8'h00;
        end else begin
            r_grant     <= '0;
            r_rnd_valid <= 1'b0;
            if (w_consume) begin
                r_last_byte <= bus.trng_data;
                r_rep_cnt   <= w_rep_next;
            end
            case (r_state)
                ST_OFF: begin
                    if (w_any_req && !r_health_fail) begin
                        r_state    <= ST_WARMUP;
                        r_enable   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_warm_cnt <= 8'd0;
                        r_rep_cnt  <= 4'd0;
                    end
                end
                ST_WARMUP: begin
                    if (w_consume) begin
                        if (w_trip) begin
                            r_state       <= ST_FAIL;
                            r_health_fail <= 1'b1;
                            r_enable      <= 1'b0;
                            r_busy        <= 1'b0;
                        end else begin
                            r_warm_cnt <= r_warm_cnt + 8'd1;
                            if (r_warm_cnt == c_WARM_LAST) begin
                                r_state    <= ST_SERVE;
                                r_idle_cnt <= 16'd0;
                            end
                        end
                    end
                end
                ST_SERVE: begin
                    if (w_consume && w_trip) begin
                        r_state       <= ST_FAIL;
                        r_health_fail <= 1'b1;
                        r_enable      <= 1'b0;
                        r_busy        <= 1'b0;
                    end else begin
                        if (w_consume) begin
                            r_grant     <= w_onehot;
                            r_rnd_valid <= 1'b1;
                            r_rnd_data  <= bus.trng_data;
                            r_rr_ptr    <= w_next_ptr;
                        end
                        if (w_any_req) begin
                            r_idle_cnt <= 16'd0;
                        end else if (r_idle_cnt == c_IDLE_LAST) begin
                            r_state  <= ST_OFF;
                            r_enable <= 1'b0;
                            r_busy   <= 1'b0;
                        end else if (r_idle_cnt != 16'hFFFF) begin
                            r_idle_cnt <= r_idle_cnt + 16'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    if (bus.clear_fail) begin
                        r_health_fail <= 1'b0;
                        r_rep_cnt     <= 4'd0;
                        r_state       <= ST_OFF;
                    end
                end
                default: r_state <= ST_OFF;
            endcase
        end
    end

    assign bus.trng_consume = w_consume;
    assign bus.grant        = r_grant;
    assign bus.rnd_data     = r_rnd_data;
    assign bus.rnd_valid    = r_rnd_valid;
    assign bus.trng_enable  = r_enable;
    assign bus.busy         = r_busy;
    assign bus.health_fail  = r_health_fail;
endmodule

`default_nettype wire

// File: tb/tb_trng_sched.sv
// ============================================================================
// Module      : tb_trng_sched
// Description : Scoreboard bench for trng_sched with a queued TRNG byte source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trng_sched;
    logic clk;
    logic rst_n;
    trng_sched_if #(.NREQ(4)) bus ();

    trng_sched #(
        .NREQ(4), .WARMUP_BYTES(4), .IDLE_CYCLES(64), .REP_LIMIT(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // TRNG byte source: bytes appended by the stimulus, popped on consume.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic       force_ready;
    logic [7:0] nb;

    assign bus.trng_data  = mem[rd_ptr];
    assign bus.trng_ready = (rd_ptr != wr_ptr) || force_ready;

    initial rd_ptr = 8'd0;
    always @(posedge clk) begin
        if (bus.trng_consume) rd_ptr <= rd_ptr + 8'd1;
    end

    logic [11:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && bus.rnd_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(bus.rnd_valid), 32'd0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("grant", 32'(bus.grant), 32'(e[11:8]));
                chk("rnd_data", 32'(bus.rnd_data), 32'(e[7:0]));
            end
        end else if (bus.grant != 4'b0000) begin
            chk("grant_without_valid", 32'(bus.grant), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic push_new();
        push(nb);
        nb = nb + 8'd1;
    endtask

    task automatic expect_grant(input logic [3:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r0;
        logic [3:0] rr_pat [0:7];
        rr_pat = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        wr_ptr = 8'd0;
        nb = 8'h80;
        force_ready = 1'b0;
        bus.req = 4'b0000;
        bus.clear_fail = 1'b0;
        rst_n = 1'b0;
        tick(2);

        // Reset values
        chk("rst_enable", 32'(bus.trng_enable), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_valid", 32'(bus.rnd_valid), 0);
        chk("rst_data", 32'(bus.rnd_data), 0);
        chk("rst_health", 32'(bus.health_fail), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;

        // Idle with no requests: source ready but nothing taken
        force_ready = 1'b1;
        r0 = rd_ptr;
        tick(200);
        chk("idle_enable", 32'(bus.trng_enable), 0);
        chk("idle_no_consume", 32'(rd_ptr - r0), 0);
        force_ready = 1'b0;

        // Warm-up discard then first served byte
        r0 = rd_ptr;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h5A);
        expect_grant(4'b0100, 8'h5A);
        bus.req = 4'b0100;
        wait_empty("first_grant_timeout");
        bus.req = 4'b0000;
        chk("warmup_consumes", 32'(rd_ptr - r0), 5);
        chk("serve_busy", 32'(bus.busy), 1);
        chk("serve_enable", 32'(bus.trng_enable), 1);

        // Round robin from a fresh reset with all requesters asserted
        do_reset();
        for (int i = 0; i < 4; i++) push_new();
        for (int i = 0; i < 8; i++) begin
            expect_grant(rr_pat[i], nb);
            push_new();
        end
        bus.req = 4'b1111;
        wait_empty("rr_timeout");
        bus.req = 4'b0000;

        // Move rr_ptr to 2, then 1010 must go to requester 3
        expect_grant(4'b0010, nb);
        push_new();
        bus.req = 4'b0010;
        wait_empty("rr2_timeout");
        bus.req = 4'b0000;
        expect_grant(4'b1000, nb);
        push_new();
        bus.req = 4'b1010;
        wait_empty("rr_wrap_timeout");
        bus.req = 4'b0000;

        // Idle timeout: enable drops on the 64th idle cycle
        tick(63);
        chk("idle63_enable", 32'(bus.trng_enable), 1);
        tick(1);
        chk("idle64_enable", 32'(bus.trng_enable), 0);
        chk("idle64_busy", 32'(bus.busy), 0);

        // Request landing in the expiry cycle keeps SERVE
        for (int i = 0; i < 4; i++) push_new();
        expect_grant(4'b0001, nb);
        push_new();
        bus.req = 4'b0001;
        wait_empty("rerun_timeout");
        bus.req = 4'b0000;
        tick(63);
        bus.req = 4'b0001;
        tick(1);
        chk("expiry_req_enable", 32'(bus.trng_enable), 1);
        chk("expiry_req_busy", 32'(bus.busy), 1);
        r0 = rd_ptr;
        expect_grant(4'b0001, nb);
        push_new();
        wait_empty("still_serve_timeout");
        chk("still_serve_no_warmup", 32'(rd_ptr - r0), 1);
        bus.req = 4'b0000;
        tick(64);
        chk("idle_again_enable", 32'(bus.trng_enable), 0);

        // Repetition health test
        for (int i = 0; i < 4; i++) push_new();
        push(8'h00); push(8'h00); push(8'h00);
        expect_grant(4'b0001, 8'h00);
        expect_grant(4'b0001, 8'h00);
        bus.req = 4'b0001;
        begin
            int n = 0;
            while (bus.health_fail !== 1'b1 && n < 100) begin
                tick(1);
                n++;
            end
        end
        chk("health_fail", 32'(bus.health_fail), 1);
        chk("fail_enable", 32'(bus.trng_enable), 0);
        chk("fail_busy", 32'(bus.busy), 0);
        chk("fail_all_consumed", 32'(rd_ptr - wr_ptr), 0);
        chk("fail_grants_done", exp_q.size(), 0);
        tick(3);
        chk("fail_sticky", 32'(bus.health_fail), 1);
        chk("fail_enable_held", 32'(bus.trng_enable), 0);
        bus.clear_fail = 1'b1;
        tick(1);
        bus.clear_fail = 1'b0;
        chk("clear_fail", 32'(bus.health_fail), 0);
        r0 = rd_ptr;
        for (int i = 0; i < 4; i++) push_new();
        expect_grant(4'b0001, nb);
        push_new();
        wait_empty("post_clear_timeout");
        chk("post_clear_warmup", 32'(rd_ptr - r0), 5);

        // Reset while a byte is being consumed in SERVE (rr_ptr is now 1)
        push_new();
        #1;
        chk("inflight_consume", 32'(bus.trng_consume), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_enable", 32'(bus.trng_enable), 0);
        chk("async_rst_consume", 32'(bus.trng_consume), 0);
        tick(1);
        chk("rst_mid_valid", 32'(bus.rnd_valid), 0);
        chk("rst_mid_grant", 32'(bus.grant), 0);
        chk("rst_mid_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 3; i++) push_new();
        expect_grant(4'b0001, nb);
        push_new();
        wait_empty("rst_rrptr_timeout");
        bus.req = 4'b0000;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
